// File: rtl/fetch_npc.sv
// Fetch front end: drives PC next-value, issues one-outstanding imem fetches, buffers 2 instructions.
// Optional STATIC_JAL_PREDICT_EN: redirect npc to the JAL target in the response cycle.
module fetch_npc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  state_t      state;
  logic [1:0]  count;
  logic [31:0] req_pc;
  entry_t      head, tail, new_e;
  logic        grant, enq, deq;
  logic        jal_hit;
  logic [31:0] jal_tgt;
  logic        unused_ok;

  assign imem_req   = (state == IDLE) && (count != 2'd2) && !redirect_valid && !rst;
  assign imem_addr  = pc_i;
  assign grant      = imem_req & imem_gnt;
  // A redirect kills both the in-flight response and any same-cycle dequeue.
  assign enq        = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign deq        = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid = (count != 2'd0);
  assign inst_pc    = head.pc;
  assign inst       = head.ins;
  assign new_e      = '{pc: req_pc, ins: imem_rdata};
  assign unused_ok  = ^redirect_target[1:0];

`ifdef STATIC_JAL_PREDICT_EN
  logic [31:0] jal_off;
  assign jal_off = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign jal_hit = enq && (imem_rdata[6:0] == 7'b1101111);
  assign jal_tgt = req_pc + jal_off;
`else
  assign jal_hit = 1'b0;
  assign jal_tgt = pc_i;
`endif

  always_comb begin
    npc_o = pc_i;
    if (rst)                 npc_o = pc_i;
    else if (redirect_valid) npc_o = {redirect_target[31:2], 2'b00};
    else if (grant)          npc_o = pc_i + 32'd4;
    else if (jal_hit)        npc_o = jal_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 2'd0;
      req_pc <= 32'd0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state  <= WAIT;
          req_pc <= pc_i;
        end
        WAIT: begin
          if (imem_rvalid)         state <= IDLE;
          else if (redirect_valid) state <= DROP;
        end
        DROP: if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (redirect_valid)    count <= 2'd0;
      else if (enq && !deq)  count <= count + 2'd1;
      else if (deq && !enq)  count <= count - 2'd1;
    end
  end

  // Head is always the oldest entry; tail only holds data when count==2.
  always_ff @(posedge clk) begin
    if (enq && (count == 2'd0 || (count == 2'd1 && deq))) head <= new_e;
    else if (deq)                                         head <= tail;
    if (enq && ((count == 2'd1 && !deq) || count == 2'd2)) tail <= new_e;
  end

endmodule

// File: tb/tb_fetch_npc.sv
// Directed bench for fetch_npc with a scoreboard queue checked by a decoupled monitor.
module tb_fetch_npc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] npc_o, imem_addr, imem_rdata, redirect_target, inst_pc, inst;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, inst_valid, inst_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_jal;

  fetch_npc dut (
    .clk(clk), .rst(rst), .pc_i(pc), .npc_o(npc_o),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // PC register closed around the DUT
  always @(posedge clk) pc <= rst ? 32'd0 : npc_o;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request cycle then response cycle; returns in the cycle the entry is at the head.
  task automatic fetch(input logic [31:0] a);
    imem_gnt = 1'b1;
    #1;
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, a);
    chk("npc_grant", npc_o, a + 32'd4);
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = mdata(a);
    exp_q.push_back('{pc: a, ins: mdata(a)});
    #1;
    chk("req_wait", {31'd0, imem_req}, 32'd0);
    chk("npc_hold_wait", npc_o, a + 32'd4);
    step();
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", inst_pc, mon_e.pc);
        chk("inst", inst, mon_e.ins);
      end
    end
  end

  initial begin
`ifdef STATIC_JAL_PREDICT_EN
    exp_jal = 32'h18;
`else
    exp_jal = 32'h24;
`endif
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0; inst_ready = 1'b1;
    step(); step();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_npc", npc_o, 32'd0);
    imem_gnt = 1'b0;
    rst = 1'b0;

    // sequential fetch, one per 2 cycles
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    #1 chk("npc_idle_hold", npc_o, 32'hC);
    step();

    // backpressure
    inst_ready = 1'b0;
    fetch(32'hC); fetch(32'h10);
    imem_gnt = 1'b1;
    #1;
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_npc", npc_o, 32'h14);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    step();
    imem_gnt = 1'b0;
    inst_ready = 1'b1;
    #1 chk("full_req2", {31'd0, imem_req}, 32'd0);
    step();
    fetch(32'h14);
    // stray response in IDLE
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_rvalid = 1'b0;
    #1 chk("stray_valid", {31'd0, inst_valid}, 32'd0);

    // redirect during WAIT
    imem_gnt = 1'b1;
    #1 chk("addr_18", imem_addr, 32'h18);
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h103;
    #1;
    chk("redir_npc", npc_o, 32'h100);
    chk("redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    chk("drop_npc", npc_o, 32'h100);
    step();
    imem_rvalid = 1'b1; imem_rdata = mdata(32'h18);
    #1 chk("drop_req2", {31'd0, imem_req}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    #1 chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'h100);

    // redirect together with response, buffer holding 0x100
    inst_ready = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("addr_104", imem_addr, 32'h104);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mdata(32'h104);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    exp_q.delete();
    #1 chk("sim_npc", npc_o, 32'h200);
    step();
    redirect_valid = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b1;
    #1;
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h200);
    step();

    // wrap with stalled grant
    redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFF;
    #1;
    chk("wrap_redir_npc", npc_o, 32'hFFFFFFFC);
    chk("wrap_redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_addr", imem_addr, 32'hFFFFFFFC);
      chk("stall_npc", npc_o, 32'hFFFFFFFC);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      step();
    end
    fetch(32'hFFFFFFFC);
    step();

    // JAL at 0x20
    redirect_valid = 1'b1; redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    #1 chk("addr_20", imem_addr, 32'h20);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hFF9FF06F;
    exp_q.push_back('{pc: 32'h20, ins: 32'hFF9FF06F});
    #1 chk("jal_npc", npc_o, exp_jal);
    step();
    imem_rvalid = 1'b0;
    #1 chk("jal_next_addr", imem_addr, exp_jal);

    // reset mid-operation, late response afterwards
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; rst = 1'b1;
    exp_q.delete();
    #1 chk("midrst_req", {31'd0, imem_req}, 32'd0);
    step();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = mdata(exp_jal);
    #1;
    chk("postrst_req", {31'd0, imem_req}, 32'd1);
    chk("postrst_addr", imem_addr, 32'd0);
    step();
    imem_rvalid = 1'b0;
    #1 chk("postrst_valid", {31'd0, inst_valid}, 32'd0);
    step(); step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
